// File: rtl/mealy_seq_detector_param.sv
// Serial Mealy detector for a run-time loadable PAT_W-bit pattern with overlap control.
// Define SEQDET_MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module mealy_seq_detector_param #(
  parameter int unsigned            PAT_W       = 4,
  parameter logic [PAT_W-1:0]       PAT_DEFAULT = 4'b1011,
  parameter int unsigned            CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       P1,
  input  logic                       in_valid,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic                       pat_load,
  input  logic                       overlap_en,
  output logic                       z,
  output logic [$clog2(PAT_W):0]     fill,
  output logic [CNT_W-1:0]           match_count
);

  localparam int unsigned FW = $clog2(PAT_W) + 1;
  localparam logic [FW-1:0] FILL_ARMED = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] window;
  logic             armed;

  assign window = {hist_q, P1};
  assign armed  = (fill_q == FILL_ARMED);
  assign z      = reset & in_valid & ~pat_load & armed & (window == pat_q);
  assign fill   = fill_q;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (z && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        // Low PAT_W-1 bits of the window drop the oldest bit; works down to PAT_W=2.
        hist_d = window[PAT_W-2:0];
        fill_d = armed ? fill_q : fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PAT_DEFAULT;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (z && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/mealy_seq_detector_param.md
Name: mealy_seq_detector_param

Overview:
- Parametrised successor to the team's fixed-pattern serial Mealy detector.
- Watches the single-bit serial input P1 for a programmable PAT_W-bit pattern, qualified by in_valid.
- Asserts z combinationally in the same cycle the final matching bit is presented (Mealy output).
- Adds run-time pattern load, selectable overlapping/non-overlapping detection and a window-fill tracker; optionally a saturating match counter.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PAT_DEFAULT, 4'b1011, pattern held after reset; width PAT_W; MSB is the first bit received.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- P1  input  1  serial data bit; sampled only when in_valid=1.
- in_valid  input  1  qualifies P1 for the current cycle.
- pat_in  input  PAT_W  new pattern value; MSB is the first bit received.
- pat_load  input  1  on a rising clk edge, copies pat_in into the pattern register.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- z  output  1  Mealy match flag; combinational.
- fill  output  clog2(PAT_W)+1  number of valid history bits, saturating at PAT_W-1.
- match_count  output  CNT_W  saturating count of matches; active only with the optional feature.

Behaviour:
- Registered state:
  - pat_reg: PAT_W bits.
  - hist: PAT_W-1 bits, the most recent valid bits, newest in the LSB.
  - fill counter.
  - match_count.
- Reset (reset=0, asynchronous):
  - pat_reg=PAT_DEFAULT, hist=0, fill=0, match_count=0.
  - z=0 while reset is low, regardless of inputs.
- z = reset & in_valid & ~pat_load & (fill==PAT_W-1) & ({hist,P1}==pat_reg).
  - Zero latency: z is valid in the same cycle as P1. It is not registered.
- On a rising edge with in_valid=1 and pat_load=0:
  - hist <= {hist[PAT_W-3:0],P1}.
  - fill <= min(fill+1, PAT_W-1).
- Match with overlap_en=1: history keeps shifting normally; a suffix of the match can start the next match.
- Match with overlap_en=0:
  - fill <= 0 and hist <= 0 on that edge.
  - A new match needs PAT_W fresh bits.
- in_valid=0: hist, fill and match_count hold; z=0.
- pat_load=1 (takes priority over in_valid):
  - pat_reg <= pat_in, hist <= 0, fill <= 0.
  - Any P1 bit presented that cycle is discarded and z=0.
  - match_count is not cleared.
- overlap_en may change at any cycle. It takes effect for the match evaluated in that same cycle.
- Reset mid-sequence: partial history is lost and pat_reg returns to PAT_DEFAULT. A loaded pattern does not survive reset.
- Fill state sequence: EMPTY(0) -> 1 -> ... -> ARMED(PAT_W-1). ARMED loops to itself on a non-match or an overlapped match, and returns to EMPTY on a non-overlapped match or pat_load.

Optional Feature:
- Macro: SEQDET_MATCH_COUNT_EN.
- Defined:
  - match_count increments on each clk edge where z=1.
  - It saturates at 2^CNT_W-1 and holds there; it does not wrap.
  - It clears only on reset.
- Not defined:
  - match_count is tied to 0 and no counter flops are synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset, PAT_DEFAULT=1011, overlap_en=1, in_valid=1; P1 = 1,0,1,1,0,1,1 -> z=1 on bit 4 and bit 7 only; with the feature enabled, match_count=2.
- Same stimulus with overlap_en=0 -> z=1 on bit 4 only; fill reads 0 after bit 4, then 1,2,3 after bits 5,6,7.
- pat_load with pat_in=0110, then P1 = 0,1,1,0,1,1,0 with overlap_en=1 -> z=1 on bits 4 and 7; also drive P1 = 1,0,1,1 -> no z pulse.
- in_valid gaps: drive 1,0 / idle 3 cycles / 1,1 -> z=1 on the final bit; no z pulse during idle cycles even with P1=1.
- Assert reset low asynchronously between clock edges after 1,0,1 -> fill=0 and z=0 immediately, pat_reg returns to PAT_DEFAULT; a following 1 gives no match, and a full 1,0,1,1 gives a match.
- Feature on, CNT_W=2, overlap_en=1: feed 1,0,1,1,0,1,1,0,1,1,0,1,1 (4 matches) -> match_count = 1,2,3,3, saturating and holding.
